pc_sequencer: RTL and testbench

//  Program counter / fetch sequencer feeding instruction memory. Consumes the absolute jump

---
 rtl/pc_sequencer_pkg.sv | 12 +
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer_ret_stack.sv | 54 +++++
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and widths for the fetch sequencer and the branch-target LUT.
package pc_pkg;

  localparam int PC_W      = 12;
  localparam int REL_OFS_W = 8;
  localparam int RET_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;

  typedef enum {NXT_SEQ, NXT_ABS, NXT_REL, NXT_CALL, NXT_RET, NXT_HOLD} pc_sel_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the sequencer and its driver (decoder, LUT, top).
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int D     = PC_W,
  parameter int OFS_W = REL_OFS_W
);

  logic             Start;
  logic [D-1:0]     StartAddr;
  logic             Stall;
  logic             Halt;
  logic             AbsJump;
  logic             RelJump;
  logic             Taken;
  logic             Call;
  logic             Ret;
  logic [D-1:0]     Target;
  logic [OFS_W-1:0] Offset;
  logic [D-1:0]     PC;
  logic             FetchEn;
  logic             Done;
  logic             StackErr;

  modport master (
    output Start, StartAddr, Stall, Halt, AbsJump, RelJump, Taken, Call, Ret, Target, Offset,
    input  PC, FetchEn, Done, StackErr
  );

  modport slave (
    input  Start, StartAddr, Stall, Halt, AbsJump, RelJump, Taken, Call, Ret, Target, Offset,
    output PC, FetchEn, Done, StackErr
  );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. Only the stack pointer is reset; stale entries are never read.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic [SP_W-1:0] sp_dec;

  assign sp_dec   = sp_q - SP_ONE;
  assign pop_data = mem_q[sp_dec[AW-1:0]];
  assign full     = (sp_q == SP_FULL);
  assign empty    = (sp_q == '0);

  always_comb begin
    sp_d = sp_q;
    if (clear)
      sp_d = '0;
    else if (push)
      sp_d = sp_q + SP_ONE;
    else if (pop)
      sp_d = sp_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sp_q <= '0;
    else
      sp_q <= sp_d;
  end

  // Storage has no reset: an entry is always written before sp can reach it.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem_q[sp_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer: picks sequential, jump, branch, call or return each cycle.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D        = PC_W,
  parameter int OFS_W    = REL_OFS_W,
  parameter int RS_DEPTH = RET_DEPTH
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [D-1:0] PC_ONE = D'(1);

  pc_state_t    state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         stack_err_q, stack_err_d;
  pc_sel_t      sel;
  logic         run_go, start_go;
  logic         ret_err, call_err;
  logic         stk_full, stk_empty;
  logic [D-1:0] pc_inc, rel_ofs, pop_data;

  assign run_go   = (state_q == RUN) && !bus.Stall;
  assign start_go = (state_q != RUN) && bus.Start;
  assign pc_inc   = pc_q + PC_ONE;
  assign rel_ofs  = {{(D-OFS_W){bus.Offset[OFS_W-1]}}, bus.Offset};

  ret_stack #(
    .DEPTH (RS_DEPTH),
    .W     (D)
  ) u_ret_stack (
    .clk       (Clk),
    .rst_n     (Reset),
    .clear     (start_go),
    .push      (sel == NXT_CALL),
    .pop       (sel == NXT_RET),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stack_err_q <= stack_err_d;
    end
  end

  // Priority: Halt > Ret > Call > taken AbsJump > taken RelJump > sequential.
  always_comb begin
    sel      = NXT_HOLD;
    ret_err  = 1'b0;
    call_err = 1'b0;
    if (run_go) begin
      if (bus.Halt)
        sel = NXT_HOLD;
      else if (bus.Ret) begin
        if (stk_empty) ret_err = 1'b1;
        else           sel = NXT_RET;
      end else if (bus.Call) begin
        if (stk_full) call_err = 1'b1;
        else          sel = NXT_CALL;
      end else if (bus.AbsJump && bus.Taken)
        sel = NXT_ABS;
      else if (bus.RelJump && bus.Taken)
        sel = NXT_REL;
      else
        sel = NXT_SEQ;
    end

    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_go) state_d = RUN;
      RUN:        if (run_go && (bus.Halt || ret_err || call_err)) state_d = DONE;
      default:    state_d = IDLE;
    endcase

    case (sel)
      NXT_SEQ:  pc_d = pc_inc;
      NXT_ABS:  pc_d = bus.Target;
      NXT_REL:  pc_d = pc_q + rel_ofs;
      NXT_CALL: pc_d = bus.Target;
      NXT_RET:  pc_d = pop_data;
      default:  pc_d = pc_q;
    endcase
    if (start_go)
      pc_d = bus.StartAddr;

    stack_err_d = start_go ? 1'b0 : (stack_err_q | ret_err | call_err);
  end

  always_comb begin
    bus.PC       = pc_q;
    bus.FetchEn  = (state_q == RUN) && !bus.Stall;
    bus.Done     = (state_q == DONE);
    bus.StackErr = stack_err_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_pc_sequencer;
  import pc_pkg::*;

  typedef struct packed {
    logic        start;
    logic [11:0] addr;
    logic        stall;
    logic        halt;
    logic        abs_j;
    logic        rel_j;
    logic        taken;
    logic        call;
    logic        ret;
    logic [11:0] tgt;
    logic [7:0]  ofs;
  } ctrl_t;

  typedef struct {
    string       name;
    logic [11:0] pc;
    logic        fe;
    logic        done;
    logic        err;
  } exp_t;

  logic Clk;
  logic Reset;
  exp_t sbQueue[$];
  int   compared   = 0;
  int   mismatched = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic ctrl_t idleC();
    ctrl_t c = '0;
    return c;
  endfunction

  function automatic ctrl_t startC(input logic [11:0] a);
    ctrl_t c = '0;
    c.start = 1'b1;
    c.addr  = a;
    return c;
  endfunction

  function automatic ctrl_t absC(input logic [11:0] t, input logic tk);
    ctrl_t c = '0;
    c.abs_j = 1'b1;
    c.taken = tk;
    c.tgt   = t;
    return c;
  endfunction

  function automatic ctrl_t relC(input logic [7:0] o, input logic tk);
    ctrl_t c = '0;
    c.rel_j = 1'b1;
    c.taken = tk;
    c.ofs   = o;
    return c;
  endfunction

  function automatic ctrl_t callC(input logic [11:0] t);
    ctrl_t c = '0;
    c.call = 1'b1;
    c.tgt  = t;
    return c;
  endfunction

  function automatic ctrl_t retC();
    ctrl_t c = '0;
    c.ret = 1'b1;
    return c;
  endfunction

  // Expected values describe the outputs seen in the same cycle the controls are driven.
  task automatic applyStimulus(input string name, input ctrl_t c, input logic [11:0] epc,
                               input logic efe, input logic edone, input logic eerr);
    exp_t e;
    bus.Start     = c.start;
    bus.StartAddr = c.addr;
    bus.Stall     = c.stall;
    bus.Halt      = c.halt;
    bus.AbsJump   = c.abs_j;
    bus.RelJump   = c.rel_j;
    bus.Taken     = c.taken;
    bus.Call      = c.call;
    bus.Ret       = c.ret;
    bus.Target    = c.tgt;
    bus.Offset    = c.ofs;
    e.name = name;
    e.pc   = epc;
    e.fe   = efe;
    e.done = edone;
    e.err  = eerr;
    sbQueue.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic checkBit(input string name, input string field, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s %s actual=%b required=%b", name, field, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compared++;
    if (bus.PC !== e.pc) begin
      mismatched++;
      $display("[TB] FAIL %s PC actual=%03h required=%03h", e.name, bus.PC, e.pc);
    end
    checkBit(e.name, "FetchEn", bus.FetchEn, e.fe);
    checkBit(e.name, "Done", bus.Done, e.done);
    checkBit(e.name, "StackErr", bus.StackErr, e.err);
  endtask

  always @(negedge Clk) begin
    if (sbQueue.size() > 0)
      checkOutput(sbQueue.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ctrl_t c;
    int    waitCycles;
    Reset = 1'b0;
    applyStimulus("t1_init", idleC(), 12'h000, 1'b0, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    applyStimulus("t1_reset", idleC(), 12'h000, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;

    applyStimulus("t1_idle",  idleC(),         12'h000, 1'b0, 1'b0, 1'b0);
    applyStimulus("t1_start", startC(12'h004), 12'h000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus("t1_seq", idleC(), 12'h004 + 12'(i), 1'b1, 1'b0, 1'b0);

    applyStimulus("t2_setup",    absC(12'h010, 1'b1), 12'h009, 1'b1, 1'b0, 1'b0);
    applyStimulus("t2_rel_neg",  relC(8'hFB, 1'b1),   12'h010, 1'b1, 1'b0, 1'b0);
    applyStimulus("t2_back",     absC(12'h010, 1'b1), 12'h00B, 1'b1, 1'b0, 1'b0);
    applyStimulus("t2_rel_pos",  relC(8'h14, 1'b1),   12'h010, 1'b1, 1'b0, 1'b0);
    applyStimulus("t2_to_fff",   absC(12'hFFF, 1'b1), 12'h024, 1'b1, 1'b0, 1'b0);
    applyStimulus("t2_wrap",     idleC(),             12'hFFF, 1'b1, 1'b0, 1'b0);
    applyStimulus("t2_rel_wrap", relC(8'hFF, 1'b1),   12'h000, 1'b1, 1'b0, 1'b0);

    applyStimulus("t3_setup",  absC(12'h020, 1'b1), 12'hFFF, 1'b1, 1'b0, 1'b0);
    applyStimulus("t3_abs_nt", absC(12'h0E0, 1'b0), 12'h020, 1'b1, 1'b0, 1'b0);
    applyStimulus("t3_abs_t",  absC(12'h0E0, 1'b1), 12'h021, 1'b1, 1'b0, 1'b0);
    applyStimulus("t3_rel_nt", relC(8'h10, 1'b0),   12'h0E0, 1'b1, 1'b0, 1'b0);

    applyStimulus("t4_setup", absC(12'h030, 1'b1), 12'h0E1, 1'b1, 1'b0, 1'b0);
    c = callC(12'h01D);
    c.rel_j = 1'b1;
    c.taken = 1'b1;
    c.ofs   = 8'h40;
    applyStimulus("t4_call",  c,                   12'h030, 1'b1, 1'b0, 1'b0);
    applyStimulus("t4_ret",   retC(),              12'h01D, 1'b1, 1'b0, 1'b0);
    applyStimulus("t4_after", idleC(),             12'h031, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus("t4_nest", callC(12'(12'h100 * (i + 1))),
                    (i == 0) ? 12'h032 : 12'(12'h100 * i), 1'b1, 1'b0, 1'b0);
    applyStimulus("t4_overflow", callC(12'h500),      12'h400, 1'b1, 1'b0, 1'b0);
    applyStimulus("t4_done",     idleC(),             12'h400, 1'b0, 1'b1, 1'b1);
    applyStimulus("t4_done_ign", absC(12'h123, 1'b1), 12'h400, 1'b0, 1'b1, 1'b1);
    applyStimulus("t4_restart",  startC(12'h050),     12'h400, 1'b0, 1'b1, 1'b1);
    applyStimulus("t4_call_a",   callC(12'h060),      12'h050, 1'b1, 1'b0, 1'b0);
    applyStimulus("t4_call_b",   callC(12'h070),      12'h060, 1'b1, 1'b0, 1'b0);
    applyStimulus("t4_ret_b",    retC(),              12'h070, 1'b1, 1'b0, 1'b0);
    applyStimulus("t4_ret_a",    retC(),              12'h061, 1'b1, 1'b0, 1'b0);

    c = absC(12'h123, 1'b1);
    c.stall = 1'b1;
    c.halt  = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus("t5_stall", c, 12'h051, 1'b0, 1'b0, 1'b0);
    c = idleC();
    c.halt = 1'b1;
    applyStimulus("t5_halt", c,       12'h051, 1'b1, 1'b0, 1'b0);
    applyStimulus("t5_done", idleC(), 12'h051, 1'b0, 1'b1, 1'b0);
    c = startC(12'h080);
    c.stall = 1'b1;
    applyStimulus("t5_start_stall", c,       12'h051, 1'b0, 1'b1, 1'b0);
    applyStimulus("t5_run",         idleC(), 12'h080, 1'b1, 1'b0, 1'b0);

    applyStimulus("t6_ret_empty", retC(),          12'h081, 1'b1, 1'b0, 1'b0);
    applyStimulus("t6_err",       idleC(),         12'h081, 1'b0, 1'b1, 1'b1);
    applyStimulus("t6_start",     startC(12'h000), 12'h081, 1'b0, 1'b1, 1'b1);
    applyStimulus("t6_run",       idleC(),         12'h000, 1'b1, 1'b0, 1'b0);
    applyStimulus("t6_call",      callC(12'h0AA),  12'h001, 1'b1, 1'b0, 1'b0);
    Reset = 1'b0;
    applyStimulus("t6_rst_mid",   idleC(),         12'h000, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    applyStimulus("t6_idle",      idleC(),         12'h000, 1'b0, 1'b0, 1'b0);
    applyStimulus("t6_start2",    startC(12'h010), 12'h000, 1'b0, 1'b0, 1'b0);
    applyStimulus("t6_ret_sp0",   retC(),          12'h010, 1'b1, 1'b0, 1'b0);
    applyStimulus("t6_err2",      idleC(),         12'h010, 1'b0, 1'b1, 1'b1);

    waitCycles = 0;
    while (sbQueue.size() > 0 && waitCycles < 10) begin
      @(posedge Clk);
      waitCycles++;
    end
    if (sbQueue.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain pending=%0d required=0", sbQueue.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
